// File: rtl/ma_channel_scheduler_if.sv
// Request/sample/result bundle between the price capture logic, the
// moving-average scheduler and the downstream consumer.
interface ma_channel_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_CH-1:0]         req;
  logic [NUM_CH*DATA_W-1:0]  sample_in;
  logic [NUM_CH-1:0]         grant;
  logic                      clr;
  logic [$clog2(NUM_CH)-1:0] clr_ch;
  logic                      avg_valid;
  logic [$clog2(NUM_CH)-1:0] avg_ch;
  logic [DATA_W-1:0]         avg_out;
  logic [NUM_CH-1:0]         warm;
  logic                      busy;

  modport master (
    output req, sample_in, clr, clr_ch,
    input  grant, avg_valid, avg_ch, avg_out, warm, busy
  );

  modport slave (
    input  req, sample_in, clr, clr_ch,
    output grant, avg_valid, avg_ch, avg_out, warm, busy
  );
endinterface

// File: rtl/ma_channel_scheduler.sv
// Round-robin shares one moving-average accumulator across NUM_CH price streams.
// Optional MA_SUPPRESS_COLD_EN: only emit results once the channel is warm.
module ma_channel_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WIN_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  ma_channel_scheduler_if.slave  bus
);
  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned WIN    = 1 << WIN_LOG2;
  localparam int unsigned SUM_W  = DATA_W + WIN_LOG2;
  localparam int unsigned FILL_W = WIN_LOG2 + 1;
  localparam int unsigned ADDR_W = CH_W + WIN_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACCUM, S_EMIT} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]     rr_q, rr_d, ch_q, ch_d, avg_ch_q, avg_ch_d;
  logic [DATA_W-1:0]   smp_q, smp_d, avg_out_q, avg_out_d, rd_data_q;
  logic                avg_valid_q, avg_valid_d, busy_q, busy_d, drop_q, drop_d;

  logic [SUM_W-1:0]    sum_q    [NUM_CH];
  logic [WIN_LOG2-1:0] wr_ptr_q [NUM_CH];
  logic [FILL_W-1:0]   fill_q   [NUM_CH];
  logic [NUM_CH-1:0]   warm_q;
  logic [DATA_W-1:0]   mem_q    [NUM_CH*WIN];

  logic                found_c, clr_hit_c, upd_c, emit_ok_c;
  logic [CH_W-1:0]     pick_c, idx_c;
  logic [DATA_W-1:0]   oldest_c;
  logic [SUM_W-1:0]    sum_new_c;
  logic [ADDR_W-1:0]   addr_c;

  // A clear aimed at the channel in flight cancels its update and result
  assign clr_hit_c = bus.clr && (bus.clr_ch == ch_q) && (state_q != S_IDLE);
  assign oldest_c  = warm_q[ch_q] ? rd_data_q : '0;
  assign sum_new_c = sum_q[ch_q] - SUM_W'(oldest_c) + SUM_W'(smp_q);
  assign upd_c     = (state_q == S_ACCUM) && !drop_q && !clr_hit_c;
  assign addr_c    = {ch_q, wr_ptr_q[ch_q]};

  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    rr_d        = rr_q;
    ch_d        = ch_q;
    smp_d       = smp_q;
    avg_valid_d = 1'b0;
    avg_ch_d    = avg_ch_q;
    avg_out_d   = avg_out_q;
    drop_d      = drop_q | clr_hit_c;
    found_c     = 1'b0;
    pick_c      = '0;
    idx_c       = '0;
    emit_ok_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          idx_c = CH_W'((32'(rr_q) + i) % NUM_CH);
          if (!found_c && bus.req[idx_c]) begin
            found_c = 1'b1;
            pick_c  = idx_c;
          end
        end
        if (found_c) begin
          grant_d[pick_c] = 1'b1;
          ch_d    = pick_c;
          smp_d   = bus.sample_in[pick_c*DATA_W +: DATA_W];
          rr_d    = CH_W'((32'(pick_c) + 1) % NUM_CH);
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ACCUM;
      S_ACCUM: state_d = S_EMIT;
      S_EMIT: begin
`ifdef MA_SUPPRESS_COLD_EN
        emit_ok_c = !(drop_q || clr_hit_c) && warm_q[ch_q];
`else
        emit_ok_c = !(drop_q || clr_hit_c);
`endif
        if (emit_ok_c) begin
          avg_valid_d = 1'b1;
          avg_ch_d    = ch_q;
          avg_out_d   = sum_q[ch_q][SUM_W-1:WIN_LOG2];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      ch_q        <= '0;
      smp_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_ch_q    <= '0;
      avg_out_q   <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      ch_q        <= ch_d;
      smp_q       <= smp_d;
      avg_valid_q <= avg_valid_d;
      avg_ch_q    <= avg_ch_d;
      avg_out_q   <= avg_out_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  // Per-channel running state; a clear always beats an update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sum_q[CH_W'(c)]    <= '0;
        wr_ptr_q[CH_W'(c)] <= '0;
        fill_q[CH_W'(c)]   <= '0;
      end
      warm_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (bus.clr && (bus.clr_ch == CH_W'(c))) begin
          sum_q[CH_W'(c)]    <= '0;
          wr_ptr_q[CH_W'(c)] <= '0;
          fill_q[CH_W'(c)]   <= '0;
          warm_q[CH_W'(c)]   <= 1'b0;
        end else if (upd_c && (ch_q == CH_W'(c))) begin
          sum_q[CH_W'(c)]    <= sum_new_c;
          wr_ptr_q[CH_W'(c)] <= wr_ptr_q[CH_W'(c)] + WIN_LOG2'(1);
          if (fill_q[CH_W'(c)] != FILL_W'(WIN))
            fill_q[CH_W'(c)] <= fill_q[CH_W'(c)] + FILL_W'(1);
          if (fill_q[CH_W'(c)] >= FILL_W'(WIN - 1))
            warm_q[CH_W'(c)] <= 1'b1;
        end
      end
    end
  end

  // History RAM: read the slot about to be overwritten, write it in ACCUM
  always_ff @(posedge clk) begin
    if (upd_c)
      mem_q[addr_c] <= smp_q;
    if (state_q == S_FETCH)
      rd_data_q <= mem_q[addr_c];
  end

  assign bus.grant     = grant_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_ch    = avg_ch_q;
  assign bus.avg_out   = avg_out_q;
  assign bus.warm      = warm_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Randomised bench for ma_channel_scheduler against a sample-history model.
module tb_ma_channel_scheduler;
  localparam int NCH = 4;
  localparam int WIN = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rr_exp   = 0;
  int unsigned hist [NCH][$];

  always #5 clk = ~clk;

  ma_channel_scheduler_if #(.NUM_CH(4), .DATA_W(8)) bus ();
  ma_channel_scheduler #(.NUM_CH(4), .DATA_W(8), .WIN_LOG2(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Model: the last WIN samples since clear; missing samples count as 0
  function automatic void m_push(int ch, int unsigned v);
    hist[ch].push_back(v);
    if (hist[ch].size() > WIN) void'(hist[ch].pop_front());
  endfunction

  function automatic void m_clear(int ch);
    hist[ch].delete();
  endfunction

  function automatic int unsigned m_avg(int ch);
    int unsigned s = 0;
    for (int i = 0; i < hist[ch].size(); i++) s += hist[ch][i];
    return s / WIN;
  endfunction

  function automatic bit m_warm(int ch);
    return hist[ch].size() == WIN;
  endfunction

  function automatic logic [NCH-1:0] m_warm_vec();
    logic [NCH-1:0] w;
    for (int c = 0; c < NCH; c++) w[c] = m_warm(c);
    return w;
  endfunction

  function automatic bit exp_valid(int ch);
`ifdef MA_SUPPRESS_COLD_EN
    return m_warm(ch);
`else
    return 1'b1;
`endif
  endfunction

  // Present one sample, wait for its grant and (optionally) its result
  task automatic op(input int ch, input logic [7:0] val, output int gch, output int lat,
                    output logic [1:0] och, output logic [7:0] oavg);
    gch = -1; lat = -1; och = '0; oavg = '0;
    bus.sample_in[ch*8 +: 8] = val;
    bus.req[ch] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        gch = -2;
        if ($onehot(bus.grant))
          for (int c = 0; c < NCH; c++) if (bus.grant[c]) gch = c;
        break;
      end
    end
    bus.req[ch] = 1'b0;
    if (gch == -1) return;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.avg_valid) begin
        lat = i; och = bus.avg_ch; oavg = bus.avg_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.sample_in = '0; bus.clr = 1'b0; bus.clr_ch = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0", bus.grant); end
    n_checks++; if (bus.avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got=%b exp=0", bus.avg_valid); end
    n_checks++; if (bus.avg_ch !== 2'd0) begin n_fail++; $display("FAIL reset_avg_ch got=%0d exp=0", bus.avg_ch); end
    n_checks++; if (bus.avg_out !== 8'd0) begin n_fail++; $display("FAIL reset_avg_out got=%0d exp=0", bus.avg_out); end
    n_checks++; if (bus.warm !== 4'b0) begin n_fail++; $display("FAIL reset_warm got=%b exp=0", bus.warm); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) m_clear(c);
    rr_exp = 0;
    @(negedge clk);
  endtask

  // Constant stream on one channel; latency, average and warm-up each sample
  task automatic test_stream(input string name, input int ch, input int n,
                             input bit rnd, input logic [7:0] val);
    int gch, lat; logic [1:0] och; logic [7:0] oavg, v; bit ev;
    for (int k = 1; k <= n; k++) begin
      v = rnd ? 8'($urandom_range(0, 255)) : val;
      op(ch, v, gch, lat, och, oavg);
      m_push(ch, int'(v)); rr_exp = (ch + 1) % NCH;
      ev = exp_valid(ch);
      n_checks++; if (gch !== ch) begin n_fail++; $display("FAIL %s_grant k=%0d got=%0d exp=%0d", name, k, gch, ch); end
      n_checks++; if (lat !== (ev ? 3 : -1)) begin n_fail++; $display("FAIL %s_latency k=%0d got=%0d exp=%0d", name, k, lat, ev ? 3 : -1); end
      if (ev) begin
        n_checks++;
        if (och !== 2'(ch) || oavg !== 8'(m_avg(ch))) begin
          n_fail++; $display("FAIL %s_avg k=%0d got ch=%0d avg=%0d exp ch=%0d avg=%0d", name, k, och, oavg, ch, m_avg(ch));
        end
      end
      n_checks++; if (bus.warm[ch] !== m_warm(ch)) begin n_fail++; $display("FAIL %s_warm k=%0d got=%b exp=%b", name, k, bus.warm[ch], m_warm(ch)); end
    end
  endtask

  task automatic test_saturate();
    test_stream("sat", 2, 40, 1'b0, 8'd255);
    n_checks++; if (dut.sum_q[2] !== 13'd8160) begin n_fail++; $display("FAIL sat_sum got=%0d exp=8160", dut.sum_q[2]); end
    n_checks++; if (m_avg(2) != 255 || dut.avg_out_q !== 8'd255) begin n_fail++; $display("FAIL sat_avg got=%0d exp=255", dut.avg_out_q); end
  endtask

  task automatic test_clr_inflight();
    bit got, saw;
    got = 1'b0; saw = 1'b0;
    bus.sample_in[15:8] = 8'd77;
    bus.req[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin got = 1'b1; break; end
    end
    n_checks++; if (!got || bus.grant !== 4'b0010) begin n_fail++; $display("FAIL clr_fetch_grant got=%b exp=0010", bus.grant); end
    bus.req[1] = 1'b0; bus.clr = 1'b1; bus.clr_ch = 2'd1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_clear(1); rr_exp = 2;
    for (int i = 0; i < 5; i++) begin
      if (bus.avg_valid) saw = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL clr_fetch_valid got=1 exp=0"); end
    n_checks++; if (bus.warm[1] !== 1'b0) begin n_fail++; $display("FAIL clr_fetch_warm got=%b exp=0", bus.warm[1]); end
    test_stream("clr_next", 1, 1, 1'b0, 8'd32);
    test_stream("other0", 0, 2, 1'b1, 8'd0);
    test_stream("other2", 2, 2, 1'b1, 8'd0);
    n_checks++; if (bus.warm !== m_warm_vec()) begin n_fail++; $display("FAIL clr_warm_vec got=%b exp=%b", bus.warm, m_warm_vec()); end
  endtask

  task automatic test_clr_at_grant();
    int lat; logic [1:0] och; logic [7:0] oavg; bit ev;
    lat = -1; och = '0; oavg = '0;
    test_stream("pre3", 3, 10, 1'b1, 8'd0);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clrg_idle got busy=%b exp=0", bus.busy); end
    bus.sample_in[31:24] = 8'd200; bus.req[3] = 1'b1;
    bus.clr = 1'b1; bus.clr_ch = 2'd3;
    @(negedge clk);
    bus.clr = 1'b0;
    n_checks++; if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL clrg_grant got=%b exp=1000", bus.grant); end
    bus.req[3] = 1'b0;
    m_clear(3); m_push(3, 200); rr_exp = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.avg_valid) begin lat = i; och = bus.avg_ch; oavg = bus.avg_out; break; end
    end
    ev = exp_valid(3);
    n_checks++; if (lat !== (ev ? 3 : -1)) begin n_fail++; $display("FAIL clrg_latency got=%0d exp=%0d", lat, ev ? 3 : -1); end
    if (ev) begin
      n_checks++; if (och !== 2'd3 || oavg !== 8'd6) begin n_fail++; $display("FAIL clrg_avg got ch=%0d avg=%0d exp ch=3 avg=6", och, oavg); end
    end
  endtask

  // All channels request continuously: strict rotation, 4-cycle spacing, tagged results
  task automatic test_round_robin();
    logic [7:0] cur [NCH];
    int exp_ch [$]; int exp_av [$];
    int grants, last_g, ec, ea;
    grants = 0; last_g = -1;
    for (int c = 0; c < NCH; c++) begin
      cur[c] = 8'($urandom_range(0, 255));
      bus.sample_in[c*8 +: 8] = cur[c];
    end
    bus.req = 4'hF;
    for (int cyc = 0; cyc < 400 && (grants < 40 || exp_ch.size() != 0); cyc++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        n_checks++; if (bus.grant !== 4'(1 << rr_exp)) begin n_fail++; $display("FAIL rr_order got=%b exp_ch=%0d", bus.grant, rr_exp); end
        if (last_g >= 0) begin
          n_checks++; if (cyc - last_g != 4) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=4", cyc - last_g); end
        end
        last_g = cyc;
        m_push(rr_exp, int'(cur[rr_exp]));
        if (exp_valid(rr_exp)) begin exp_ch.push_back(rr_exp); exp_av.push_back(int'(m_avg(rr_exp))); end
        cur[rr_exp] = 8'($urandom_range(0, 255));
        bus.sample_in[rr_exp*8 +: 8] = cur[rr_exp];
        rr_exp = (rr_exp + 1) % NCH;
        grants++;
        if (grants == 40) bus.req = '0;
      end
      if (bus.avg_valid) begin
        ec = -1; ea = -1;
        if (exp_ch.size() != 0) begin ec = exp_ch.pop_front(); ea = exp_av.pop_front(); end
        n_checks++;
        if (int'(bus.avg_ch) != ec || int'(bus.avg_out) != ea) begin
          n_fail++; $display("FAIL rr_result got ch=%0d avg=%0d exp ch=%0d avg=%0d", bus.avg_ch, bus.avg_out, ec, ea);
        end
      end
    end
    bus.req = '0;
    n_checks++; if (grants != 40 || exp_ch.size() != 0) begin n_fail++; $display("FAIL rr_complete got grants=%0d pending=%0d exp 40/0", grants, exp_ch.size()); end
  endtask

  task automatic test_rst_mid();
    bit got;
    got = 1'b0;
    bus.sample_in[7:0] = 8'd99; bus.req[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin got = 1'b1; break; end
    end
    bus.req[0] = 1'b0;
    n_checks++; if (!got) begin n_fail++; $display("FAIL rst_mid_grant got=none exp=0001"); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 4'b0 || bus.avg_valid !== 1'b0 || bus.avg_ch !== 2'd0 ||
        bus.avg_out !== 8'd0 || bus.warm !== 4'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got g=%b v=%b ch=%0d avg=%0d warm=%b busy=%b exp all 0",
                         bus.grant, bus.avg_valid, bus.avg_ch, bus.avg_out, bus.warm, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) m_clear(c);
    rr_exp = 0;
    @(negedge clk);
    test_stream("post_rst", 0, 1, 1'b0, 8'd64);
  endtask

  initial begin
    test_reset();
    test_stream("ramp", 0, 32, 1'b0, 8'd64);
    test_stream("decay", 0, 32, 1'b0, 8'd0);
    test_stream("random1", 1, 40, 1'b1, 8'd0);
    test_saturate();
    test_clr_inflight();
    test_clr_at_grant();
    test_round_robin();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end
endmodule
